// File: rtl/csr_row_sequencer.sv
// Row sequencer for CSR sparse-matrix x dense-vector: walks row pointers and non-zeros,
// issuing one first/last-flagged beat per non-zero (one empty beat per empty row).
module csr_row_sequencer #(
    parameter int N_ROWS = 560,
    parameter int ROW_AW = 10,
    parameter int NNZ_AW = 14,
    parameter int COL_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ROW_AW-1:0] row_addr,
    input  logic [31:0]       row_ptr,
    output logic [NNZ_AW-1:0] nz_addr,
    input  logic [31:0]       nz_val,
    input  logic [31:0]       nz_col,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [31:0]       iss_val,
    output logic [COL_W-1:0]  iss_col,
    output logic [ROW_AW-1:0] iss_row,
    output logic              iss_first,
    output logic              iss_last,
    output logic              iss_empty
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_P0A,
        S_P0C,
        S_PNA,
        S_PNC,
        S_NA,
        S_NC,
        S_ISS,
        S_EMP,
        S_ADV,
        S_DONE
    } state_t;

    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(N_ROWS - 1);
    localparam logic [ROW_AW-1:0] ROW_ONE  = ROW_AW'(1);
    localparam logic [ROW_AW-1:0] ROW_TWO  = ROW_AW'(2);
    localparam logic [NNZ_AW-1:0] NNZ_ONE  = NNZ_AW'(1);

    state_t             state_q, state_d;
    logic [ROW_AW-1:0]  row_q, row_d;
    logic [ROW_AW-1:0]  row_addr_q, row_addr_d;
    logic [NNZ_AW-1:0]  nz_addr_q, nz_addr_d;
    logic [31:0]        sptr_q, sptr_d;
    logic [31:0]        eptr_q, eptr_d;
    logic [31:0]        idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               valid_q, valid_d;
    logic [31:0]        val_q, val_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic               empty_q, empty_d;
    logic               hs;
    logic               unused_col_hi;

    // Only the low COL_W bits of the column RAM word address the vector.
    assign unused_col_hi = ^nz_col[31:COL_W];

    assign hs = valid_q & iss_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            row_addr_q <= '0;
            nz_addr_q  <= '0;
            sptr_q     <= '0;
            eptr_q     <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            val_q      <= '0;
            col_q      <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            empty_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            row_addr_q <= row_addr_d;
            nz_addr_q  <= nz_addr_d;
            sptr_q     <= sptr_d;
            eptr_q     <= eptr_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            val_q      <= val_d;
            col_q      <= col_d;
            first_q    <= first_d;
            last_q     <= last_d;
            empty_q    <= empty_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        row_addr_d = row_addr_q;
        nz_addr_d  = nz_addr_q;
        sptr_d     = sptr_q;
        eptr_d     = eptr_q;
        idx_d      = idx_q;
        err_d      = err_q;
        valid_d    = valid_q;
        val_d      = val_q;
        col_d      = col_q;
        first_d    = first_q;
        last_d     = last_q;
        empty_d    = empty_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_d      = '0;
                    row_addr_d = '0;
                    err_d      = 1'b0;
                    state_d    = S_P0A;
                end
            end
            S_P0A: state_d = S_P0C;
            S_P0C: begin
                sptr_d     = row_ptr;
                row_addr_d = row_q + ROW_ONE;
                state_d    = S_PNA;
            end
            S_PNA: state_d = S_PNC;
            S_PNC: begin
                eptr_d = row_ptr;
                // A decreasing pointer is flagged and the row is treated as empty.
                if (row_ptr <= sptr_q) begin
                    if (row_ptr < sptr_q) begin
                        err_d = 1'b1;
                    end
                    valid_d = 1'b1;
                    empty_d = 1'b1;
                    first_d = 1'b1;
                    last_d  = 1'b1;
                    val_d   = '0;
                    col_d   = '0;
                    state_d = S_EMP;
                end else begin
                    nz_addr_d = sptr_q[NNZ_AW-1:0];
                    idx_d     = sptr_q;
                    first_d   = 1'b1;
                    state_d   = S_NA;
                end
            end
            S_NA: state_d = S_NC;
            S_NC: begin
                val_d   = nz_val;
                col_d   = nz_col[COL_W-1:0];
                last_d  = (idx_q + 32'd1 == eptr_q);
                empty_d = 1'b0;
                valid_d = 1'b1;
                state_d = S_ISS;
            end
            S_ISS: begin
                if (hs) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = S_ADV;
                    end else begin
                        idx_d     = idx_q + 32'd1;
                        nz_addr_d = nz_addr_q + NNZ_ONE;
                        first_d   = 1'b0;
                        state_d   = S_NA;
                    end
                end
            end
            S_EMP: begin
                if (hs) begin
                    valid_d = 1'b0;
                    empty_d = 1'b0;
                    state_d = S_ADV;
                end
            end
            S_ADV: begin
                if (row_q == LAST_ROW) begin
                    state_d = S_DONE;
                end else begin
                    // The end pointer of this row is the start of the next; no re-read.
                    row_d      = row_q + ROW_ONE;
                    sptr_d     = eptr_q;
                    row_addr_d = row_q + ROW_TWO;
                    state_d    = S_PNA;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign row_addr  = row_addr_q;
    assign nz_addr   = nz_addr_q;
    assign iss_valid = valid_q;
    assign iss_val   = val_q;
    assign iss_col   = col_q;
    assign iss_row   = row_q;
    assign iss_first = first_q;
    assign iss_last  = last_q;
    assign iss_empty = empty_q;

endmodule
